mmio_address_control: RTL and testbench
=======================================

Name: mmio_address_control

Overview:
Parametrised memory-mapped I/O decoder between the processor data port and data memory. It claims a window of word addresses starting at BASE_ADDR and provides:
- N_IN debounced input channels (switches).
- A sticky change-status register.
- N_OUT read/write output registers (image/LED channels).

Memory writes into the window are suppressed. Reads from the window replace memory read data.

Parameters:
BASE_ADDR, 32'd81928, first word address of the MMIO window
N_IN, 2, number of input channels (1..8)
IN_W, 5, width of each input channel (1..32)
N_OUT, 2, number of output registers (1..8)
OUT_W, 8, width of each output register (1..32)
DEBOUNCE, 4, consecutive stable cycles needed to accept an input change (>=1)

Ports:
CLK  in  1  system clock, all state updates on rising edge
RST  in  1  synchronous active-high reset
A  in  32  data address from processor
WD  in  32  write data from processor
WE_IN  in  1  processor write enable
RD  in  32  read data from data memory
SWITCH  in  N_IN*IN_W  asynchronous input channels; channel i = SWITCH[i*IN_W +: IN_W]
WE_OUT  out  1  write enable forwarded to data memory
RD_OUT  out  32  read data returned to processor
IMAGE  out  N_OUT*OUT_W  output registers; channel j = IMAGE[j*OUT_W +: OUT_W]
CHANGE_IRQ  out  1  OR of all status bits

Behaviour:
Clock and reset: one clock (CLK); reset is synchronous and active-high (RST).

Address map (offset = A - BASE_ADDR):
- 0 .. N_IN-1: input channel i, read-only, value = debounced IN_W bits, zero-extended to 32.
- N_IN: STATUS, bit i = sticky change flag of channel i, upper bits read 0.
- N_IN+1 .. N_IN+N_OUT: output register j (offset N_IN+1+j), read/write, readback = OUT_W bits, zero-extended.
- HIT = (A >= BASE_ADDR) && (A < BASE_ADDR+N_IN+1+N_OUT). Comparison is unsigned 32-bit with no wrap. A window crossing 2^32 is a parameter error, flagged by an elaboration assertion.

Forwarding:
- WE_OUT = WE_IN && !HIT. Combinational, zero latency, for every hit offset, including read-only ones.
- RD_OUT = HIT ? mmio_read : RD. Combinational from A and current register state.

Writes (rising edge, WE_IN && HIT):
- Output register offset: reg[j] <= WD[OUT_W-1:0]. IMAGE updates the cycle after the write edge.
- STATUS offset: write-1-to-clear, status[i] <= 0 where WD[i]=1.
- Input offsets: ignored, no state change.

Input path, per channel, independent:
- 2-flop synchroniser sync1 -> sync2.
- Counter cnt, width clog2(DEBOUNCE+1), and stable register.
- If sync2 == stable: cnt <= 0.
- Else if cnt == DEBOUNCE-1: stable <= sync2, cnt <= 0, status[i] <= 1.
- Else: cnt <= cnt+1.
- A glitch shorter than DEBOUNCE cycles at sync2 never reaches stable.
- Latency from a SWITCH change to stable update = 2 + DEBOUNCE cycles.

Simultaneous events:
- Status set and W1C on the same bit in the same cycle: set wins, bit remains 1.
- Output register write and RST in the same cycle: RST wins.

CHANGE_IRQ = |status. Combinational from registers, so no extra latency.

Reset (RST=1 at an edge): sync1, sync2, stable, cnt, status and all output registers <= 0. As a result, IMAGE=0, CHANGE_IRQ=0, and RD_OUT in the window reads 0. Reset mid-debounce discards the pending change; after reset, a SWITCH value that is still nonzero is re-detected from 0 with full latency.

Test Plan:
- Reset, then A=81928, SWITCH ch0=5'h13 held -> RD_OUT=0 for 5 cycles, then RD_OUT=32'h13 at cycle 6 (2+DEBOUNCE), STATUS (A=81930) reads 32'h1, CHANGE_IRQ=1.
- WE_IN=1, A=81931, WD=32'hABCD_12F0 -> WE_OUT=0, IMAGE[7:0]=8'hF0 next cycle; read A=81931 -> RD_OUT=32'hF0. A=81932, WD=8'h5A -> IMAGE[15:8]=8'h5A.
- WE_IN=1, A=81927 and A=81933, WD=32'h1 -> WE_OUT=1, IMAGE unchanged, RD_OUT=RD (drive RD=32'hDEAD_BEEF, expect passthrough).
- ch1 toggles 5'h00->5'h1F for 3 cycles then back -> stable stays 0, status bit1 stays 0. Held 4+ cycles -> RD_OUT at A=81929 becomes 32'h1F, status=2'b10.
- With status=2'b11, write A=81930 WD=32'h1 in the same cycle as a ch0 debounce completion -> status stays 2'b11. Next write WD=32'h3 -> status=0, CHANGE_IRQ=0.
- Write IMAGE ch0=8'h77, then assert RST for 1 cycle during a ch0 debounce count -> IMAGE=0, status=0, RD_OUT(81928)=0. A held SWITCH value is reported again after 2+DEBOUNCE cycles.

Source files
------------

// File: rtl/mmio_address_control.sv
// Memory-mapped I/O decoder: debounced input channels, a sticky change-status
// register and read/write output registers, overlaid on the data-memory port.
module mmio_address_control #(
   parameter logic [31:0] BASE_ADDR = 32'd81928,
   parameter int          N_IN      = 2,
   parameter int          IN_W      = 5,
   parameter int          N_OUT     = 2,
   parameter int          OUT_W     = 8,
   parameter int          DEBOUNCE  = 4
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [31:0]            A,
   input  logic [31:0]            WD,
   input  logic                   WE_IN,
   input  logic [31:0]            RD,
   input  logic [N_IN*IN_W-1:0]   SWITCH,
   output logic                   WE_OUT,
   output logic [31:0]            RD_OUT,
   output logic [N_OUT*OUT_W-1:0] IMAGE,
   output logic                   CHANGE_IRQ
);

   localparam int WIN       = N_IN + 1 + N_OUT;
   localparam int CNT_W     = (DEBOUNCE + 1 > 1) ? $clog2(DEBOUNCE + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
   localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + 33'(WIN);

   // The window must not wrap past the top of the 32-bit address space.
   if (WIN_END > 33'h1_0000_0000) begin : g_bad_window
      $fatal(1, "mmio_address_control: window crosses 2^32");
   end
   if (N_IN < 1 || N_IN > 8 || N_OUT < 1 || N_OUT > 8 || IN_W < 1 || IN_W > 32 ||
       OUT_W < 1 || OUT_W > 32 || DEBOUNCE < 1) begin : g_bad_params
      $fatal(1, "mmio_address_control: parameter out of range");
   end

   logic [IN_W-1:0]  sync1   [N_IN];
   logic [IN_W-1:0]  sync2   [N_IN];
   logic [IN_W-1:0]  stable  [N_IN];
   logic [CNT_W-1:0] cnt     [N_IN];
   logic [N_IN-1:0]  status;
   logic [OUT_W-1:0] out_reg [N_OUT];

   logic        hit;
   logic [31:0] offset;
   logic [31:0] mmio_read;
   logic        wr_hit;
   logic        unused_wd;

   assign hit       = ({1'b0, A} >= {1'b0, BASE_ADDR}) && ({1'b0, A} < WIN_END);
   assign offset    = A - BASE_ADDR;
   assign wr_hit    = WE_IN && hit;
   assign unused_wd = ^WD;

   assign WE_OUT     = WE_IN && !hit;
   assign RD_OUT     = hit ? mmio_read : RD;
   assign CHANGE_IRQ = |status;

   for (genvar j = 0; j < N_OUT; j++) begin : g_image
      assign IMAGE[j*OUT_W +: OUT_W] = out_reg[j];
   end

   always_comb begin
      mmio_read = 32'd0;
      for (int i = 0; i < N_IN; i++) begin
         if (offset == 32'(i)) mmio_read = 32'(stable[i]);
      end
      if (offset == 32'(N_IN)) mmio_read = 32'(status);
      for (int j = 0; j < N_OUT; j++) begin
         if (offset == 32'(N_IN + 1 + j)) mmio_read = 32'(out_reg[j]);
      end
   end

   // The debounce set is applied after the write-1-to-clear so that a
   // coincident set always wins.
   always_ff @(posedge CLK) begin
      if (RST) begin
         status <= '0;
         for (int i = 0; i < N_IN; i++) begin
            sync1[i]  <= '0;
            sync2[i]  <= '0;
            stable[i] <= '0;
            cnt[i]    <= '0;
         end
         for (int j = 0; j < N_OUT; j++) begin
            out_reg[j] <= '0;
         end
      end else begin
         if (wr_hit && offset == 32'(N_IN)) begin
            status <= status & ~WD[N_IN-1:0];
         end
         for (int i = 0; i < N_IN; i++) begin
            sync1[i] <= SWITCH[i*IN_W +: IN_W];
            sync2[i] <= sync1[i];
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               stable[i] <= sync2[i];
               cnt[i]    <= '0;
               status[i] <= 1'b1;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
         for (int j = 0; j < N_OUT; j++) begin
            if (wr_hit && offset == 32'(N_IN + 1 + j)) begin
               out_reg[j] <= WD[OUT_W-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_mmio_address_control.sv
// Directed-vector bench for mmio_address_control with hand-computed expectations.
module tb_mmio_address_control;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] A;
   logic [31:0] WD;
   logic        WE_IN;
   logic [31:0] RD;
   logic [9:0]  SWITCH;
   logic        WE_OUT;
   logic [31:0] RD_OUT;
   logic [15:0] IMAGE;
   logic        CHANGE_IRQ;

   int vectors = 0;
   int miscompares = 0;

   mmio_address_control dut (
      .CLK(CLK), .RST(RST), .A(A), .WD(WD), .WE_IN(WE_IN), .RD(RD),
      .SWITCH(SWITCH), .WE_OUT(WE_OUT), .RD_OUT(RD_OUT), .IMAGE(IMAGE),
      .CHANGE_IRQ(CHANGE_IRQ)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Inputs change 2 time units after the rising edge and are sampled there too.
   task automatic applyStimulus(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge CLK);
         #2;
      end
   endtask

   task automatic readAt(input string tag, input logic [31:0] addr,
                         input logic [31:0] expected);
      A = addr;
      #1;
      checkOutput(tag, RD_OUT, expected);
   endtask

   initial begin
      RST = 1'b1; A = 32'd81928; WD = '0; WE_IN = 1'b0;
      RD = 32'hDEAD_BEEF; SWITCH = '0;
      applyStimulus(2);
      RST = 1'b0;
      #1;
      checkOutput("reset_rd_ch0", RD_OUT, 32'h0);
      checkOutput("reset_image", {16'h0, IMAGE}, 32'h0);
      checkOutput("reset_irq", {31'h0, CHANGE_IRQ}, 32'h0);

      SWITCH = {5'h00, 5'h13};
      A = 32'd81928;
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(1);
         checkOutput($sformatf("ch0_latency_%0d", k), RD_OUT, 32'h0);
      end
      applyStimulus(1);
      checkOutput("ch0_debounced", RD_OUT, 32'h13);
      readAt("status_after_ch0", 32'd81930, 32'h1);
      checkOutput("irq_after_ch0", {31'h0, CHANGE_IRQ}, 32'h1);
      readAt("ch1_idle", 32'd81929, 32'h0);

      WE_IN = 1'b1; A = 32'd81931; WD = 32'hABCD_12F0;
      #1;
      checkOutput("we_out_hit_img0", {31'h0, WE_OUT}, 32'h0);
      checkOutput("image_before_edge", {16'h0, IMAGE}, 32'h0);
      applyStimulus(1);
      checkOutput("image_ch0_f0", {16'h0, IMAGE}, 32'h0000_00F0);
      WE_IN = 1'b0;
      readAt("readback_img0", 32'd81931, 32'hF0);
      WE_IN = 1'b1; A = 32'd81932; WD = 32'h0000_005A;
      applyStimulus(1);
      checkOutput("image_ch1_5a", {16'h0, IMAGE}, 32'h0000_5AF0);
      WE_IN = 1'b0;
      readAt("readback_img1", 32'd81932, 32'h5A);

      WE_IN = 1'b1; A = 32'd81928; WD = 32'hFFFF_FFFF;
      #1;
      checkOutput("we_out_hit_input", {31'h0, WE_OUT}, 32'h0);
      applyStimulus(1);
      checkOutput("input_write_ignored", RD_OUT, 32'h13);

      WD = 32'h1; A = 32'd81927;
      #1;
      checkOutput("we_out_below", {31'h0, WE_OUT}, 32'h1);
      checkOutput("rd_pass_below", RD_OUT, 32'hDEAD_BEEF);
      applyStimulus(1);
      A = 32'd81933;
      #1;
      checkOutput("we_out_above", {31'h0, WE_OUT}, 32'h1);
      checkOutput("rd_pass_above", RD_OUT, 32'hDEAD_BEEF);
      applyStimulus(1);
      checkOutput("image_unchanged", {16'h0, IMAGE}, 32'h0000_5AF0);
      A = 32'hFFFF_FFFF;
      #1;
      checkOutput("rd_pass_top", RD_OUT, 32'hDEAD_BEEF);

      A = 32'd81930; WD = 32'h1;
      applyStimulus(1);
      WE_IN = 1'b0;
      #1;
      checkOutput("status_w1c", RD_OUT, 32'h0);
      checkOutput("irq_cleared", {31'h0, CHANGE_IRQ}, 32'h0);

      SWITCH = {5'h1F, 5'h13};
      applyStimulus(3);
      SWITCH = {5'h00, 5'h13};
      applyStimulus(6);
      readAt("ch1_glitch_rejected", 32'd81929, 32'h0);
      readAt("status_glitch", 32'd81930, 32'h0);

      SWITCH = {5'h1F, 5'h13};
      A = 32'd81929;
      applyStimulus(5);
      checkOutput("ch1_not_yet", RD_OUT, 32'h0);
      applyStimulus(1);
      checkOutput("ch1_debounced", RD_OUT, 32'h1F);
      readAt("status_ch1", 32'd81930, 32'h2);

      SWITCH = {5'h1F, 5'h0A};
      applyStimulus(6);
      readAt("status_both", 32'd81930, 32'h3);

      SWITCH = {5'h1F, 5'h07};
      applyStimulus(5);
      readAt("ch0_still_0a", 32'd81928, 32'h0A);
      WE_IN = 1'b1; A = 32'd81930; WD = 32'h1;
      applyStimulus(1);
      WE_IN = 1'b0;
      readAt("set_beats_w1c", 32'd81930, 32'h3);
      readAt("ch0_now_07", 32'd81928, 32'h07);
      WE_IN = 1'b1; A = 32'd81930; WD = 32'h3;
      applyStimulus(1);
      WE_IN = 1'b0;
      readAt("status_all_clear", 32'd81930, 32'h0);
      checkOutput("irq_all_clear", {31'h0, CHANGE_IRQ}, 32'h0);

      WE_IN = 1'b1; A = 32'd81931; WD = 32'h77;
      applyStimulus(1);
      WE_IN = 1'b0;
      #1;
      checkOutput("image_77", {16'h0, IMAGE}, 32'h0000_5A77);
      SWITCH = {5'h1F, 5'h15};
      applyStimulus(3);
      RST = 1'b1; WE_IN = 1'b1; A = 32'd81932; WD = 32'h33;
      applyStimulus(1);
      RST = 1'b0; WE_IN = 1'b0;
      #1;
      checkOutput("reset_beats_write", {16'h0, IMAGE}, 32'h0);
      checkOutput("irq_after_reset", {31'h0, CHANGE_IRQ}, 32'h0);
      readAt("status_after_reset", 32'd81930, 32'h0);
      readAt("ch1_after_reset", 32'd81929, 32'h0);
      A = 32'd81928;
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(1);
         checkOutput($sformatf("redetect_wait_%0d", k), RD_OUT, 32'h0);
      end
      applyStimulus(1);
      checkOutput("redetect_ch0", RD_OUT, 32'h15);
      readAt("redetect_ch1", 32'd81929, 32'h1F);
      readAt("redetect_status", 32'd81930, 32'h3);
      checkOutput("redetect_irq", {31'h0, CHANGE_IRQ}, 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
